// File: rtl/ball_pkg.sv
// Shared constants for the ball animation objects: state encoding, screen
// geometry and default court layout. The renderer and hoop drawer use it too.
package ball_pkg;

  localparam logic [1:0] ST_READY  = 2'd0;
  localparam logic [1:0] ST_FLIGHT = 2'd1;
  localparam logic [1:0] ST_SCORE  = 2'd2;
  localparam logic [1:0] ST_MISS   = 2'd3;

  localparam int BALL_RADIUS = 4;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;

  localparam int DEF_START_X     = 40;
  localparam int DEF_START_Y     = 400;
  localparam int DEF_GRAVITY     = 1;
  localparam int DEF_HOOP_Y      = 200;
  localparam int DEF_HOOP_X_L    = 540;
  localparam int DEF_HOOP_X_R    = 570;
  localparam int DEF_FLOOR_Y     = SCREEN_H - 20;
  localparam int DEF_X_MIN       = BALL_RADIUS;
  localparam int DEF_X_MAX       = SCREEN_W - BALL_RADIUS - 1;
  localparam int DEF_V_TICK_ROW  = SCREEN_H + 1;
  localparam int DEF_HOLD_FRAMES = 30;

  // Positions are 11-bit signed, velocities 8-bit signed, and next-position
  // sums are widened to 12 bits so nothing wraps before the compares.
  typedef logic signed [10:0] pos_t;
  typedef logic signed [7:0]  vel_t;
  typedef logic signed [11:0] sum_t;

  function automatic sum_t clamp_s(input sum_t v, input sum_t lo, input sum_t hi);
    sum_t r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/ball_trajectory_if.sv
// Control-in / ball-state-out bundle between the controls, the trajectory
// engine and the VGA ball renderer.
interface ball_trajectory_if;
  logic [9:0] pixel_y;
  logic       shoot;
  logic [5:0] launch_vx;
  logic [5:0] launch_vy;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       in_flight;
  logic       score_pulse;
  logic       miss_pulse;
  logic [7:0] made_count;

  modport slave (
    input  pixel_y, shoot, launch_vx, launch_vy,
    output ball_x, ball_y, in_flight, score_pulse, miss_pulse, made_count
  );

  modport master (
    output pixel_y, shoot, launch_vx, launch_vy,
    input  ball_x, ball_y, in_flight, score_pulse, miss_pulse, made_count
  );
endinterface

// File: rtl/frame_tick_gen.sv
// One-clock pulse per video frame, taken from the rising edge of a registered
// compare of the scan row against ROW. Independent of clocks per pixel.
module frame_tick_gen #(
  parameter int ROW = 481
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pixel_y,
  output logic       frame_tick
);

  logic row_hit_q, row_hit_d;
  logic hit_prev_q, hit_prev_d;

  // Row compare and one-cycle-delayed copy for edge detection
  always_comb begin
    row_hit_d  = (pixel_y == 10'(ROW));
    hit_prev_d = row_hit_q;
  end

  // Compare and edge-detect registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_hit_q  <= 1'b0;
      hit_prev_q <= 1'b0;
    end else begin
      row_hit_q  <= row_hit_d;
      hit_prev_q <= hit_prev_d;
    end
  end

  assign frame_tick = row_hit_q & ~hit_prev_q;

endmodule

// File: rtl/ball_trajectory.sv
// Per-frame shot physics: launch, gravity, hoop crossing, floor/wall miss,
// then a hold period and return to the start position.
//
// state  | meaning
// READY  | ball parked at start, waiting for shoot
// FLIGHT | ball moving, physics step on every frame tick
// SCORE  | made shot, ball frozen for HOLD_FRAMES ticks
// MISS   | floor or wall hit, ball frozen for HOLD_FRAMES ticks
module ball_trajectory
  import ball_pkg::*;
#(
  parameter int START_X     = DEF_START_X,
  parameter int START_Y     = DEF_START_Y,
  parameter int GRAVITY     = DEF_GRAVITY,
  parameter int HOOP_Y      = DEF_HOOP_Y,
  parameter int HOOP_X_L    = DEF_HOOP_X_L,
  parameter int HOOP_X_R    = DEF_HOOP_X_R,
  parameter int FLOOR_Y     = DEF_FLOOR_Y,
  parameter int X_MIN       = DEF_X_MIN,
  parameter int X_MAX       = DEF_X_MAX,
  parameter int V_TICK_ROW  = DEF_V_TICK_ROW,
  parameter int HOLD_FRAMES = DEF_HOLD_FRAMES
) (
  input logic         clk,
  input logic         reset,
  ball_trajectory_if.slave bus
);

  localparam sum_t HOOP_Y_S  = sum_t'(HOOP_Y);
  localparam sum_t HOOP_XL_S = sum_t'(HOOP_X_L);
  localparam sum_t HOOP_XR_S = sum_t'(HOOP_X_R);
  localparam sum_t FLOOR_Y_S = sum_t'(FLOOR_Y);
  localparam sum_t X_MIN_S   = sum_t'(X_MIN);
  localparam sum_t X_MAX_S   = sum_t'(X_MAX);
  localparam pos_t START_X_P = pos_t'(START_X);
  localparam pos_t START_Y_P = pos_t'(START_Y);

  logic [1:0] state_q, state_d;
  pos_t       x_q, x_d, y_q, y_d;
  vel_t       vx_q, vx_d, vy_q, vy_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] made_q, made_d;
  logic       in_flight_q, in_flight_d;
  logic       score_q, score_d;
  logic       miss_q, miss_d;

  logic       frame_tick;
  sum_t       x_n, y_n, x_clamp;
  logic [8:0] vy_sum;
  vel_t       vy_grav;
  logic       hit_make, hit_floor, hit_wall;

  frame_tick_gen #(.ROW(V_TICK_ROW)) u_frame_tick (
    .clk        (clk),
    .reset      (reset),
    .pixel_y    (bus.pixel_y),
    .frame_tick (frame_tick)
  );

  // Candidate next position, gravity update and the three outcome tests
  always_comb begin
    x_n     = sum_t'(x_q) + sum_t'(vx_q);
    y_n     = sum_t'(y_q) + sum_t'(vy_q);
    vy_sum  = {vy_q[7], vy_q} + 9'(GRAVITY);
    vy_grav = ($signed(vy_sum) > 9'sd127) ? 8'sd127 : vel_t'(vy_sum[7:0]);
    x_clamp = clamp_s(x_n, X_MIN_S, X_MAX_S);
    // The make only counts on the way down through the rim row
    hit_make  = (vy_q > 8'sd0) && (sum_t'(y_q) < HOOP_Y_S) && (y_n >= HOOP_Y_S) &&
                (x_n >= HOOP_XL_S) && (x_n <= HOOP_XR_S);
    hit_floor = (y_n >= FLOOR_Y_S);
    hit_wall  = (x_n > X_MAX_S) || (x_n < X_MIN_S);
  end

  // Shot state machine plus pulse/count/flag next values
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    hold_d  = hold_q;
    case (state_q)
      ST_READY: begin
        x_d = START_X_P;
        y_d = START_Y_P;
        if (bus.shoot) begin
          vx_d    = vel_t'({2'b00, bus.launch_vx});
          vy_d    = vel_t'(8'd0 - {2'b00, bus.launch_vy});
          state_d = ST_FLIGHT;
        end
      end
      ST_FLIGHT: begin
        if (frame_tick) begin
          vy_d = vy_grav;
          if (hit_make) begin
            state_d = ST_SCORE;
            x_d     = pos_t'(x_n);
            y_d     = pos_t'(HOOP_Y_S);
          end else if (hit_floor) begin
            state_d = ST_MISS;
            x_d     = pos_t'(x_clamp);
            y_d     = pos_t'(FLOOR_Y_S);
          end else if (hit_wall) begin
            state_d = ST_MISS;
            x_d     = pos_t'(x_clamp);
            y_d     = pos_t'(y_n);
          end else begin
            x_d = pos_t'(x_n);
            y_d = pos_t'(y_n);
          end
        end
      end
      ST_SCORE, ST_MISS: begin
        if (frame_tick) begin
          hold_d = hold_q + 8'd1;
          if (hold_d == 8'(HOLD_FRAMES)) begin
            state_d = ST_READY;
            x_d     = START_X_P;
            y_d     = START_Y_P;
            vx_d    = 8'sd0;
            vy_d    = 8'sd0;
            hold_d  = 8'd0;
          end
        end
      end
      default: state_d = ST_READY;
    endcase

    score_d     = (state_d == ST_SCORE) && (state_q != ST_SCORE);
    miss_d      = (state_d == ST_MISS) && (state_q != ST_MISS);
    made_d      = (score_d && (made_q != 8'hFF)) ? made_q + 8'd1 : made_q;
    in_flight_d = (state_d == ST_FLIGHT);
  end

  // State, kinematics and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_READY;
      x_q         <= START_X_P;
      y_q         <= START_Y_P;
      vx_q        <= 8'sd0;
      vy_q        <= 8'sd0;
      hold_q      <= 8'd0;
      made_q      <= 8'd0;
      in_flight_q <= 1'b0;
      score_q     <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      hold_q      <= hold_d;
      made_q      <= made_d;
      in_flight_q <= in_flight_d;
      score_q     <= score_d;
      miss_q      <= miss_d;
    end
  end

  assign bus.ball_x      = x_q[9:0];
  assign bus.ball_y      = y_q[9:0];
  assign bus.in_flight   = in_flight_q;
  assign bus.score_pulse = score_q;
  assign bus.miss_pulse  = miss_q;
  assign bus.made_count  = made_q;

endmodule

// File: tb/tb_ball_trajectory.sv
// Bench for ball_trajectory: table of hand-derived shots, random shots
// against a closed-form trajectory model, reset and saturation sequences.
module tb_ball_trajectory;

  localparam int SX = 40, SY = 400, HY = 200, HXL = 540, HXR = 570;
  localparam int FY = 460, XMN = 4, XMX = 635, HOLD = 30;
  localparam int K_NONE = 0, K_SCORE = 1, K_MISS = 2;

  typedef struct {
    int vx; int vy; bit coinc; int kind; int kend; int fx; int fy;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   m_made = 0;
  vec_t vecs[5];

  ball_trajectory_if bus();

  ball_trajectory dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Closed-form position after k frame ticks from the start point
  function automatic int pos_x(input int vx, input int k);
    return SX + vx * k;
  endfunction
  function automatic int pos_y(input int vy, input int k);
    return SY - vy * k + (k * (k - 1)) / 2;
  endfunction
  function automatic int clampx(input int x);
    return (x > XMX) ? XMX : ((x < XMN) ? XMN : x);
  endfunction

  // Find the first tick with an outcome, in make/floor/wall priority order
  task automatic predict(input int vx, input int vy,
                         output int kind, output int kend, output int fx, output int fy);
    int nx, ny, py;
    kind = K_NONE; kend = 0; fx = 0; fy = 0; py = SY;
    for (int k = 1; k <= 400 && kind == K_NONE; k++) begin
      nx = pos_x(vx, k);
      ny = pos_y(vy, k);
      if ((k - 1 - vy) > 0 && py < HY && ny >= HY && nx >= HXL && nx <= HXR) begin
        kind = K_SCORE; fx = nx; fy = HY;
      end else if (ny >= FY) begin
        kind = K_MISS; fx = clampx(nx); fy = FY;
      end else if (nx > XMX || nx < XMN) begin
        kind = K_MISS; fx = clampx(nx); fy = ny;
      end
      if (kind != K_NONE) kend = k;
      py = ny;
    end
  endtask

  // One video frame: a single row-481 clock, then two clocks elsewhere.
  // with_shoot raises shoot during the cycle the frame tick is high.
  task automatic do_frame(input bit with_shoot);
    @(negedge clk); bus.pixel_y = 10'd481;
    @(negedge clk); bus.pixel_y = 10'd0;
    if (with_shoot) bus.shoot = 1'b1;
    @(negedge clk); bus.shoot = 1'b0;
  endtask

  task automatic run_shot(input int vx, input int vy, input bit coinc,
                          input int kind, input int kend, input int fx, input int fy);
    bus.launch_vx = 6'(vx);
    bus.launch_vy = 6'(vy);
    if (coinc) do_frame(1'b1);
    else begin
      @(negedge clk); bus.shoot = 1'b1;
      @(negedge clk); bus.shoot = 1'b0;
    end
    chk("launch_x", int'(bus.ball_x), SX);
    chk("launch_y", int'(bus.ball_y), SY);
    chk("launch_in_flight", int'(bus.in_flight), 1);
    if (kind == K_SCORE) m_made = (m_made < 255) ? m_made + 1 : 255;
    for (int k = 1; k <= kend; k++) begin
      if (k == 3 && kend > 3) begin
        @(negedge clk); bus.shoot = 1'b1;
        bus.launch_vx = 6'($urandom); bus.launch_vy = 6'($urandom);
        @(negedge clk); bus.shoot = 1'b0;
      end
      do_frame(1'b0);
      if (k < kend) begin
        chk("flight_x", int'(bus.ball_x), pos_x(vx, k) & 1023);
        chk("flight_y", int'(bus.ball_y), pos_y(vy, k) & 1023);
        chk("flight_in_flight", int'(bus.in_flight), 1);
        chk("flight_no_pulse", int'(bus.score_pulse | bus.miss_pulse), 0);
      end else begin
        chk("end_score_pulse", int'(bus.score_pulse), (kind == K_SCORE) ? 1 : 0);
        chk("end_miss_pulse", int'(bus.miss_pulse), (kind == K_MISS) ? 1 : 0);
        chk("end_x", int'(bus.ball_x), fx);
        chk("end_y", int'(bus.ball_y), fy & 1023);
        chk("end_in_flight", int'(bus.in_flight), 0);
        chk("end_made", int'(bus.made_count), m_made);
      end
    end
    @(negedge clk);
    chk("pulse_one_clk", int'(bus.score_pulse | bus.miss_pulse), 0);
    for (int h = 1; h <= HOLD; h++) begin
      do_frame(h == HOLD - 1);
      chk("hold_in_flight", int'(bus.in_flight), 0);
      if (h < HOLD) begin
        chk("hold_x", int'(bus.ball_x), fx);
        chk("hold_y", int'(bus.ball_y), fy & 1023);
      end else begin
        chk("return_x", int'(bus.ball_x), SX);
        chk("return_y", int'(bus.ball_y), SY);
      end
    end
  endtask

  initial begin
    int kind, kend, fx, fy, rvx, rvy;
    bus.pixel_y = 10'd0; bus.shoot = 1'b0;
    bus.launch_vx = 6'd0; bus.launch_vy = 6'd0;

    //          vx  vy coinc kind     kend  fx   fy
    vecs[0] = '{ 0,  0, 1'b0, K_MISS,  12,  40, 460}; // drop
    vecs[1] = '{ 4, 10, 1'b1, K_MISS,  26, 144, 460}; // arc, launch on a tick
    vecs[2] = '{12, 25, 1'b0, K_SCORE, 42, 544, 200}; // make on descent
    vecs[3] = '{13, 25, 1'b0, K_MISS,  46, 635, 285}; // crossing outside window, wall
    vecs[4] = '{63,  5, 1'b0, K_MISS,  10, 635, 395}; // wall

    repeat (2) @(negedge clk);
    chk("rst_x", int'(bus.ball_x), SX);
    chk("rst_y", int'(bus.ball_y), SY);
    chk("rst_in_flight", int'(bus.in_flight), 0);
    chk("rst_pulses", int'(bus.score_pulse | bus.miss_pulse), 0);
    chk("rst_made", int'(bus.made_count), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      run_shot(vecs[i].vx, vecs[i].vy, vecs[i].coinc,
               vecs[i].kind, vecs[i].kend, vecs[i].fx, vecs[i].fy);

    for (int i = 0; i < 6; i++) begin
      rvx = int'($urandom_range(0, 63));
      rvy = int'($urandom_range(0, 40));
      predict(rvx, rvy, kind, kend, fx, fy);
      run_shot(rvx, rvy, 1'($urandom_range(0, 1)), kind, kend, fx, fy);
    end

    // Asynchronous reset in the middle of a flight
    bus.launch_vx = 6'd5; bus.launch_vy = 6'd15;
    @(negedge clk); bus.shoot = 1'b1;
    @(negedge clk); bus.shoot = 1'b0;
    repeat (5) do_frame(1'b0);
    chk("pre_rst_x", int'(bus.ball_x), pos_x(5, 5));
    @(negedge clk); #2 reset = 1'b1;
    #1;
    chk("async_rst_x", int'(bus.ball_x), SX);
    chk("async_rst_y", int'(bus.ball_y), SY);
    chk("async_rst_in_flight", int'(bus.in_flight), 0);
    chk("async_rst_made", int'(bus.made_count), 0);
    chk("async_rst_pulses", int'(bus.score_pulse | bus.miss_pulse), 0);
    m_made = 0;
    @(negedge clk); reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_pulses", int'(bus.score_pulse | bus.miss_pulse), 0);
      chk("post_rst_in_flight", int'(bus.in_flight), 0);
    end

    // 256 consecutive makes: count must stop at 255
    predict(20, 20, kind, kend, fx, fy);
    for (int i = 0; i < 256; i++) run_shot(20, 20, 1'b0, kind, kend, fx, fy);
    chk("made_saturated", int'(bus.made_count), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ball_trajectory.md
Name: ball_trajectory

Overview:
- Produces the ball centre coordinates (ball_x, ball_y) that the ball renderer consumes.
- Runs shot physics once per video frame: launch, constant gravity, hoop-crossing detection, floor/wall miss detection, then a hold period and reset to the start position.
- Sits between the user controls/debouncer and the VGA object renderer, and is clocked in the system clock domain.

Parameters:
- START_X, 40, ball centre X in READY (pixels)
- START_Y, 400, ball centre Y in READY (pixels, screen Y grows downward)
- GRAVITY, 1, added to vertical velocity each frame (pixels/frame²)
- HOOP_Y, 200, hoop rim row
- HOOP_X_L, 540, leftmost ball-centre X that counts as a make
- HOOP_X_R, 570, rightmost ball-centre X that counts as a make
- FLOOR_Y, 460, ball-centre Y at or beyond which the shot is a miss
- X_MIN, 4, minimum legal ball-centre X (equals the ball radius)
- X_MAX, 635, maximum legal ball-centre X
- V_TICK_ROW, 481, pixel_y row whose rising detection defines the frame tick
- HOLD_FRAMES, 30, frames spent in SCORE or MISS before returning to READY

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pixel_y  in  10  current scan row from the VGA sync generator
- shoot  in  1  debounced single-cycle launch request
- launch_vx  in  6  horizontal launch speed, unsigned, pixels/frame, rightward
- launch_vy  in  6  vertical launch speed, unsigned magnitude, upward
- ball_x  out  10  ball centre X
- ball_y  out  10  ball centre Y
- in_flight  out  1  high while in FLIGHT
- score_pulse  out  1  one-cycle pulse on entry to SCORE
- miss_pulse  out  1  one-cycle pulse on entry to MISS
- made_count  out  8  number of made shots, saturates at 255

Behaviour:
- Reset: clk and reset as stated above (one clock; reset asynchronous, active-high).
  - State = READY; ball_x = START_X; ball_y = START_Y.
  - Velocities = 0; hold counter = 0; made_count = 0.
  - in_flight = 0; score_pulse = 0; miss_pulse = 0.
  - Edge-detect register is cleared.
- Frame tick:
  - frame_tick is a one-clk pulse on the rising edge of (pixel_y == V_TICK_ROW), using a registered compare.
  - There is exactly one tick per frame, regardless of how many clk cycles per pixel.
- Internal arithmetic:
  - Positions are 11-bit signed; velocities are 8-bit signed.
  - Next-position sums are computed at 12-bit signed, so there is no wrap before the compares.
- READY state:
  - The ball holds at the start position.
  - shoot=1 latches vx = launch_vx and vy = -launch_vy, then moves to FLIGHT on the next clk.
  - The position does not change in that cycle.
  - shoot coincident with frame_tick behaves identically; the first motion happens on the next tick.
- FLIGHT state, on each frame_tick:
  - Compute x_n = x + vx and y_n = y + vy, then vy <= vy + GRAVITY (saturating at +127).
  - Checks are evaluated in this priority order:
    1. Make: vy > 0 (before the add) and y < HOOP_Y <= y_n and HOOP_X_L <= x_n <= HOOP_X_R. Go to SCORE and place the ball at (x_n, HOOP_Y).
    2. Floor: y_n >= FLOOR_Y. Go to MISS and set ball_y = FLOOR_Y, ball_x = x_n clamped to [X_MIN, X_MAX].
    3. Wall: x_n > X_MAX or x_n < X_MIN. Go to MISS, clamp x, set ball_y = y_n.
    4. Otherwise the ball moves to (x_n, y_n).
  - y_n < 0 (above the screen) is legal. ball_y is then driven as the low 10 bits; the renderer simply shows nothing.
  - shoot is ignored in FLIGHT, SCORE and MISS.
- SCORE and MISS states:
  - The ball is frozen.
  - The hold counter increments on each frame_tick.
  - On the tick where the count reaches HOLD_FRAMES, return to READY: ball = start position, velocities = 0, counter = 0.
- Pulses and count:
  - score_pulse and miss_pulse are high for exactly the one clk in which the state register enters SCORE or MISS.
  - made_count increments in that same cycle for SCORE.
- in_flight is registered and equals (state == FLIGHT).
- Output timing: all outputs are registered; ball_x/ball_y change only in the clk after a frame_tick or on a READY return.
- Reset asserted mid-flight: immediate return to reset values, with no pulse generated.

Decomposition:
- Shared package (ball_pkg): state encoding (READY, FLIGHT, SCORE, MISS), BALL_RADIUS = 4, screen extents 640x480, and default hoop/floor constants, also used by the renderer and the hoop drawer.
- One sub-module, frame_tick_gen: the pixel_y compare, edge detect and tick pulse. It is reusable by other per-frame animators.

Test Plan:
- Drop test: shoot with vx=0, vy=0 at start (40,400).
  - After tick k, ball_y = 400 + k(k-1)/2, e.g. 455 at k=11.
  - Tick 12 gives MISS with ball_y = 460 and ball_x = 40, and miss_pulse high for one clk.
- Arc test: vx=4, vy=10.
  - After tick 1: (44,390), vy = -9.
  - After tick 10: (80,345) at the apex.
  - No pulses are generated before the descent.
- Make test: vx=20, vy=25 with HOOP_X_L/R adjusted to bracket the computed crossing x.
  - On the descending crossing of row 200: score_pulse, ball_y = 200, made_count 0 -> 1.
  - The same shot with the window moved away yields no make and continues to MISS.
- Wall test: vx=63, vy=5.
  - On the tick where x_n > 635: MISS with ball_x = 635.
  - shoot pulsed during flight has no effect on the trajectory.
- Hold/return test: after MISS, count 30 ticks.
  - On the 30th tick the state is READY and the ball is at (40,400).
  - A shoot on tick 29 is ignored; a shoot after the return launches.
- Reset test: assert reset mid-flight, asynchronously between clk edges.
  - Outputs return to (40,400) immediately; in_flight=0, made_count=0, no pulses.
  - Saturation: 256 consecutive makes leave made_count at 255.
